// File: rtl/sprite_spi_pkg.sv
// Shared types and constants for the sprite loading serial link
// (transmitter RTL and receiver-side models).
package sprite_spi_pkg;

   typedef logic [7:0] byte_t;

   typedef enum logic [1:0] {
      IDLE,
      LOW,
      HIGH
   } spi_tx_state_t;

   localparam int SPI_BITS            = 8;
   localparam int SPI_CLK_DIV_DEFAULT = 4;

endpackage

// File: rtl/sprite_spi_tx_fifo.sv
// Byte FIFO feeding the sprite SPI shifter; first-word-fall-through read,
// power-of-two depth so the pointers wrap naturally.
module sprite_spi_tx_fifo
   import sprite_spi_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(DEPTH);

   byte_t          mem [DEPTH];
   logic [AW-1:0]  wr_ptr_reg;
   logic [AW-1:0]  rd_ptr_reg;
   logic [AW:0]    count_reg;
   logic           do_push;
   logic           do_pop;

   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= din;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/sprite_spi_tx.sv
// Sprite link transmitter: buffered bytes shifted out MSB-first on spi_clk/spi_data.
// Optional SPI_TX_FRAME_GATE_EN holds each burst until a next_frame pulse.
module sprite_spi_tx
   import sprite_spi_pkg::*;
#(
   parameter int CLK_DIV = SPI_CLK_DIV_DEFAULT,
   parameter int DEPTH   = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       spi_clk,
   output logic       spi_data,
   output logic       busy
`ifdef SPI_TX_FRAME_GATE_EN
   ,
   input  logic       next_frame
`endif
);

   spi_tx_state_t state_reg, state_next;
   logic [7:0]    div_reg, div_next;
   logic [2:0]    bit_reg, bit_next;
   byte_t         shift_reg, shift_next;
   logic          spi_clk_reg, spi_clk_next;
   logic          pop;
   logic          start_ok;
   logic          div_tc;
   logic          fifo_full;
   logic          fifo_empty;
   byte_t         fifo_dout;

   sprite_spi_tx_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (tx_valid),
      .pop     (pop),
      .din     (tx_data),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

`ifdef SPI_TX_FRAME_GATE_EN
   logic start_pending_reg, start_pending_next;

   // Pulses only arm the start while idle; a burst in flight ignores them.
   always_comb begin
      start_pending_next = start_pending_reg;
      if (pop && state_reg == IDLE) begin
         start_pending_next = 1'b0;
      end else if (next_frame && state_reg == IDLE) begin
         start_pending_next = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) start_pending_reg <= 1'b0;
      else          start_pending_reg <= start_pending_next;
   end

   assign start_ok = start_pending_reg;
`else
   assign start_ok = 1'b1;
`endif

   assign div_tc   = (div_reg == 8'(CLK_DIV - 1));
   assign tx_ready = !fifo_full;
   assign busy     = (state_reg != IDLE) || !fifo_empty;
   assign spi_clk  = spi_clk_reg;
   // spi_data is the shifter MSB, itself a flop; it is cleared on return to IDLE.
   assign spi_data = shift_reg[7];

   always_comb begin
      state_next   = state_reg;
      div_next     = div_reg;
      bit_next     = bit_reg;
      shift_next   = shift_reg;
      spi_clk_next = spi_clk_reg;
      pop          = 1'b0;
      case (state_reg)
         IDLE: begin
            div_next     = '0;
            spi_clk_next = 1'b0;
            shift_next   = '0;
            if (!fifo_empty && start_ok) begin
               pop        = 1'b1;
               shift_next = fifo_dout;
               bit_next   = 3'(SPI_BITS - 1);
               state_next = LOW;
            end
         end
         LOW: begin
            if (div_tc) begin
               div_next     = '0;
               spi_clk_next = 1'b1;
               state_next   = HIGH;
            end else begin
               div_next = div_reg + 8'd1;
            end
         end
         HIGH: begin
            if (div_tc) begin
               div_next     = '0;
               spi_clk_next = 1'b0;
               state_next   = LOW;
               if (bit_reg != 3'd0) begin
                  shift_next = {shift_reg[6:0], 1'b0};
                  bit_next   = bit_reg - 3'd1;
               end else if (!fifo_empty) begin
                  pop        = 1'b1;
                  shift_next = fifo_dout;
                  bit_next   = 3'(SPI_BITS - 1);
               end else begin
                  shift_next = '0;
                  state_next = IDLE;
               end
            end else begin
               div_next = div_reg + 8'd1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg   <= IDLE;
         div_reg     <= '0;
         bit_reg     <= '0;
         shift_reg   <= '0;
         spi_clk_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         div_reg     <= div_next;
         bit_reg     <= bit_next;
         shift_reg   <= shift_next;
         spi_clk_reg <= spi_clk_next;
      end
   end

endmodule

// File: tb/tb_sprite_spi_tx.sv
// Directed bench for sprite_spi_tx (CLK_DIV=2, DEPTH=4) with a rising-edge
// receiver model; define SPI_TX_FRAME_GATE_EN to cover the frame gate too.
module tb_sprite_spi_tx;
   import sprite_spi_pkg::*;

   localparam int CLK_DIV = 2;
   localparam int DEPTH   = 4;

   logic       clk;
   logic       reset_n;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       spi_clk;
   logic       spi_data;
   logic       busy;

   int total;
   int bad;

`ifdef SPI_TX_FRAME_GATE_EN
   logic auto_frame;
   logic frame_pulse;
   logic next_frame;
   assign next_frame = auto_frame | frame_pulse;
`endif

   sprite_spi_tx #(
      .CLK_DIV (CLK_DIV),
      .DEPTH   (DEPTH)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .spi_clk    (spi_clk),
      .spi_data   (spi_data),
      .busy       (busy)
`ifdef SPI_TX_FRAME_GATE_EN
      ,
      .next_frame (next_frame)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Receiver model: sample on spi_clk rise, frame by bit count from reset.
   byte_t      rx_q[$];
   int         rises;
   logic [7:0] rx_sh;
   int         rx_n;

   initial begin
      rises = 0;
      rx_n  = 0;
      rx_sh = '0;
   end

   always @(posedge spi_clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_n = 0;
      end else begin
         rx_sh = {rx_sh[6:0], spi_data};
         rises = rises + 1;
         rx_n  = rx_n + 1;
         if (rx_n == SPI_BITS) begin
            rx_q.push_back(rx_sh);
            rx_n = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Holds tx_valid until the byte is taken; returns 1 ns after the accepting edge.
   task automatic push_byte(input byte_t b);
      logic acc;
      acc      = 1'b0;
      tx_data  = b;
      tx_valid = 1'b1;
      for (int i = 0; i < 2000 && !acc; i++) begin
         acc = tx_ready;
         tick();
      end
      tx_valid = 1'b0;
      if (!acc) begin
         total++; bad++;
         $display("FAIL push_timeout: byte %02h not accepted, tx_ready=%b", b, tx_ready);
      end
   endtask

   task automatic wait_idle(input int limit);
      int n;
      n = 0;
      while (busy && n < limit) begin
         tick();
         n++;
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL idle_timeout: busy=%b after %0d cycles, want 0", busy, n);
      end
   endtask

   task automatic test_reset();
      reset_n  = 1'b0;
      tx_valid = 1'b0;
      tx_data  = '0;
`ifdef SPI_TX_FRAME_GATE_EN
      auto_frame  = 1'b1;
      frame_pulse = 1'b0;
`endif
      repeat (3) tick();
      total += 4;
      if (spi_clk !== 1'b0)  begin bad++; $display("FAIL reset_spi_clk: got %b want 0", spi_clk); end
      if (spi_data !== 1'b0) begin bad++; $display("FAIL reset_spi_data: got %b want 0", spi_data); end
      if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      if (tx_ready !== 1'b1) begin bad++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
      reset_n = 1'b1;
      repeat (2) tick();
   endtask

   task automatic test_single_byte();
      int base, r0, first, bcnt;
      logic prev;
      base = rx_q.size();
      r0   = rises;
      push_byte(8'hA5);
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_after_push: got %b want 1", busy); end
      first = -1;
      bcnt  = 0;
      prev  = spi_clk;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (spi_clk && !prev && first < 0) first = k;
         prev = spi_clk;
         if (busy) bcnt++;
      end
      total += 6;
      if (first != 3)        begin bad++; $display("FAIL single_first_rise: got cycle %0d want 3", first); end
      if (bcnt != 32)        begin bad++; $display("FAIL single_busy_len: got %0d want 32", bcnt); end
      if (rises - r0 != 8)   begin bad++; $display("FAIL single_rises: got %0d want 8", rises - r0); end
      if (spi_clk !== 1'b0)  begin bad++; $display("FAIL single_idle_clk: got %b want 0", spi_clk); end
      if (spi_data !== 1'b0) begin bad++; $display("FAIL single_idle_data: got %b want 0", spi_data); end
      if (rx_q.size() != base + 1 || rx_q[base] !== 8'hA5) begin
         bad++;
         $display("FAIL single_byte: got %0d bytes last=%02h want 1 byte a5",
                  rx_q.size() - base, (rx_q.size() > base) ? rx_q[rx_q.size()-1] : 8'h00);
      end
   endtask

   task automatic test_back_to_back();
      byte_t exp[3];
      int base, r0, first, last;
      logic prev;
      exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'h3C;
      base = rx_q.size();
      r0   = rises;
      for (int i = 0; i < 3; i++) push_byte(exp[i]);
      first = -1;
      last  = -1;
      prev  = spi_clk;
      for (int k = 0; k < 200; k++) begin
         tick();
         if (spi_clk && !prev) begin
            if (first < 0) first = k;
            last = k;
         end
         prev = spi_clk;
      end
      wait_idle(100);
      total += 2;
      if (rises - r0 != 24) begin bad++; $display("FAIL b2b_rises: got %0d want 24", rises - r0); end
      if (last - first != 23 * 2 * CLK_DIV) begin
         bad++;
         $display("FAIL b2b_span: got %0d cycles first-to-last rise want %0d", last - first, 23 * 2 * CLK_DIV);
      end
      for (int i = 0; i < 3; i++) begin
         total++;
         if (rx_q.size() <= base + i || rx_q[base+i] !== exp[i]) begin
            bad++;
            $display("FAIL b2b_byte%0d: got %02h want %02h", i,
                     (rx_q.size() > base + i) ? rx_q[base+i] : 8'h00, exp[i]);
         end
      end
   endtask

   task automatic test_full();
      byte_t d[6];
      logic  acc[6];
      logic  a;
      int    acc_edge, base;
      d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44; d[4] = 8'h55; d[5] = 8'h66;
      base = rx_q.size();
      for (int i = 0; i < 6; i++) begin
         tx_data  = d[i];
         tx_valid = 1'b1;
         acc[i]   = tx_ready;
         tick();
      end
      for (int i = 0; i < 6; i++) begin
         total++;
         if (acc[i] !== (i < 5)) begin
            bad++;
            $display("FAIL full_accept%0d: got %b want %b", i, acc[i], (i < 5));
         end
      end
      total++;
      if (tx_ready !== 1'b0) begin bad++; $display("FAIL full_ready_low: got %b want 0", tx_ready); end
      acc_edge = -1;
      for (int j = 6; j < 100 && acc_edge < 0; j++) begin
         a = tx_ready;
         tick();
         if (a) acc_edge = j;
      end
      tx_valid = 1'b0;
      total++;
      if (acc_edge != 2 + 16 * CLK_DIV) begin
         bad++;
         $display("FAIL full_sixth_accept: got edge %0d want %0d", acc_edge, 2 + 16 * CLK_DIV);
      end
      wait_idle(600);
      for (int i = 0; i < 6; i++) begin
         total++;
         if (rx_q.size() <= base + i || rx_q[base+i] !== d[i]) begin
            bad++;
            $display("FAIL full_byte%0d: got %02h want %02h", i,
                     (rx_q.size() > base + i) ? rx_q[base+i] : 8'h00, d[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int base;
      base = rx_q.size();
      push_byte(8'h81);
      push_byte(8'h7E);
      repeat (14) tick();
      total += 2;
      if (spi_clk !== 1'b1) begin bad++; $display("FAIL mid_pre_clk: got %b want 1", spi_clk); end
      if (busy !== 1'b1)    begin bad++; $display("FAIL mid_pre_busy: got %b want 1", busy); end
      #2 reset_n = 1'b0;
      #1;
      total += 4;
      if (spi_clk !== 1'b0)  begin bad++; $display("FAIL mid_spi_clk: got %b want 0", spi_clk); end
      if (spi_data !== 1'b0) begin bad++; $display("FAIL mid_spi_data: got %b want 0", spi_data); end
      if (busy !== 1'b0)     begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
      if (tx_ready !== 1'b1) begin bad++; $display("FAIL mid_tx_ready: got %b want 1", tx_ready); end
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      tick();
      push_byte(8'h5A);
      wait_idle(200);
      repeat (4) tick();
      total += 2;
      if (rx_q.size() != base + 1) begin
         bad++;
         $display("FAIL mid_count: got %0d bytes want 1", rx_q.size() - base);
      end
      if (rx_q.size() < base + 1 || rx_q[rx_q.size()-1] !== 8'h5A) begin
         bad++;
         $display("FAIL mid_byte: got %02h want 5a",
                  (rx_q.size() > 0) ? rx_q[rx_q.size()-1] : 8'h00);
      end
   endtask

`ifdef SPI_TX_FRAME_GATE_EN
   task automatic test_frame_gate();
      int base, r0, first, last;
      logic prev, saw_clk;
      auto_frame = 1'b0;
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      base = rx_q.size();
      r0   = rises;
      push_byte(8'hA1);
      push_byte(8'h5E);
      saw_clk = 1'b0;
      for (int k = 0; k < 100; k++) begin
         tick();
         if (spi_clk) saw_clk = 1'b1;
      end
      total += 2;
      if (saw_clk !== 1'b0) begin bad++; $display("FAIL gate_hold: spi_clk=%b seen before next_frame, want 0", saw_clk); end
      if (busy !== 1'b1)    begin bad++; $display("FAIL gate_busy: got %b want 1", busy); end
      frame_pulse = 1'b1;
      tick();
      frame_pulse = 1'b0;
      first = -1;
      last  = -1;
      prev  = spi_clk;
      for (int k = 0; k < 80; k++) begin
         tick();
         if (k == 20) frame_pulse = 1'b1;
         if (k == 21) frame_pulse = 1'b0;
         if (spi_clk && !prev) begin
            if (first < 0) first = k;
            last = k;
         end
         prev = spi_clk;
      end
      wait_idle(100);
      total += 4;
      if (rises - r0 != 16) begin bad++; $display("FAIL gate_rises: got %0d want 16", rises - r0); end
      if (last - first != 15 * 2 * CLK_DIV) begin
         bad++;
         $display("FAIL gate_span: got %0d want %0d", last - first, 15 * 2 * CLK_DIV);
      end
      if (rx_q.size() != base + 2 || rx_q[base] !== 8'hA1 || rx_q[base+1] !== 8'h5E) begin
         bad++;
         $display("FAIL gate_bytes: got %0d bytes want a1 5e", rx_q.size() - base);
      end
      push_byte(8'hC3);
      saw_clk = 1'b0;
      for (int k = 0; k < 50; k++) begin
         tick();
         if (spi_clk) saw_clk = 1'b1;
      end
      if (saw_clk !== 1'b0) begin bad++; $display("FAIL gate_no_extra_start: spi_clk=%b want 0", saw_clk); end
      frame_pulse = 1'b1;
      tick();
      frame_pulse = 1'b0;
      wait_idle(100);
      total++;
      if (rx_q.size() != base + 3 || rx_q[base+2] !== 8'hC3) begin
         bad++;
         $display("FAIL gate_third: got %0d bytes want 3 ending c3", rx_q.size() - base);
      end
      auto_frame = 1'b1;
      repeat (2) tick();
   endtask
`endif

   task automatic test_soak();
      byte_t exp[$];
      byte_t b;
      int base;
      base = rx_q.size();
      for (int i = 0; i < 200; i++) begin
         b = 8'($urandom_range(0, 255));
         push_byte(b);
         exp.push_back(b);
         repeat ($urandom_range(0, 3)) tick();
      end
      wait_idle(8000);
      repeat (4) tick();
      total++;
      if (rx_q.size() != base + 200) begin
         bad++;
         $display("FAIL soak_count: got %0d bytes want 200", rx_q.size() - base);
      end
      for (int i = 0; i < 200; i++) begin
         total++;
         if (rx_q.size() <= base + i || rx_q[base+i] !== exp[i]) begin
            bad++;
            $display("FAIL soak_byte%0d: got %02h want %02h", i,
                     (rx_q.size() > base + i) ? rx_q[base+i] : 8'h00, exp[i]);
         end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_full();
      test_reset_mid();
`ifdef SPI_TX_FRAME_GATE_EN
      test_frame_gate();
`endif
      test_soak();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
